// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, FSM state codes and queue-entry layout for mem_access_unit
package mem_access_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_RD_ISSUE = 3'd1;
  localparam state_t S_RD_WAIT  = 3'd2;
  localparam state_t S_WR_ISSUE = 3'd3;
  localparam state_t S_WR_WAIT  = 3'd4;
  localparam state_t S_FL_ISSUE = 3'd5;
  localparam state_t S_FL_WAIT  = 3'd6;

  // Tag width is a top-level parameter, so the tag is appended outside this struct.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_body_t;

  localparam int BODY_W = $bits(req_body_t);

endpackage

// File: rtl/mem_access_fifo.sv
// rtl/mem_access_fifo.sv - synchronous FIFO with full/empty flags, asynchronous active-low reset
module mem_access_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - in-order load/store/flush initiator for the DataCache poll-until-success ports
// Optional wait-state watchdog enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [ADDR_W-1:0]    reqAddr,
  input  logic [DATA_W-1:0]    reqData,
  input  logic [TAG_WIDTH-1:0] reqTag,
  output logic                 respValid,
  output logic [DATA_W-1:0]    respData,
  output logic [TAG_WIDTH-1:0] respTag,
  input  logic                 flushReq,
  output logic                 flushDone,
  output logic [ADDR_W-1:0]    readPtr,
  input  logic [DATA_W-1:0]    readValue,
  input  logic                 readSuccess,
  output logic                 writeEnable,
  output logic [ADDR_W-1:0]    writePtr,
  output logic [DATA_W-1:0]    writeValue,
  input  logic                 writeSuccess,
  output logic                 allWriteBack,
  input  logic                 allWriteBackSuccess,
  output logic                 timeoutError
);

  localparam int ENTRY_W = BODY_W + TAG_WIDTH;

  state_t               state;
  logic                 run;
  logic                 flush_pending;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [ENTRY_W-1:0]   head_raw;
  req_body_t            head;
  logic [TAG_WIDTH-1:0] head_tag;
  logic                 rd_done;
  logic                 wr_done;
  logic                 fl_done;
  logic                 op_done;
  logic                 wd_expire;
  logic                 abort;

  // run keeps reqReady low while reset is asserted and for the first cycle after.
  assign reqReady = run && !fifo_full && !flush_pending;
  assign push     = reqValid && reqReady;
  assign {head, head_tag} = head_raw;

  assign rd_done = (state == S_RD_WAIT) && readSuccess;
  assign wr_done = (state == S_WR_WAIT) && writeSuccess;
  assign fl_done = (state == S_FL_WAIT) && allWriteBackSuccess;
  assign op_done = rd_done || wr_done || fl_done;
  assign abort   = wd_expire && !op_done;
  assign pop     = rd_done || wr_done ||
                   (abort && ((state == S_RD_WAIT) || (state == S_WR_WAIT)));

  mem_access_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({reqWrite, reqAddr, reqData, reqTag}),
    .pop       (pop),
    .head      (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            in_wait;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_err;

  assign in_wait   = (state == S_RD_WAIT) || (state == S_WR_WAIT) || (state == S_FL_WAIT);
  assign wd_expire = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (in_wait && !op_done && !wd_expire) wd_cnt <= wd_cnt + 1'b1;
      else                                   wd_cnt <= '0;
      if (abort) wd_err <= 1'b1;
    end
  end

  assign timeoutError = wd_err;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign wd_expire      = 1'b0;
  assign timeoutError   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      run           <= 1'b0;
      flush_pending <= 1'b0;
      respValid     <= 1'b0;
      respData      <= '0;
      respTag       <= '0;
      flushDone     <= 1'b0;
      readPtr       <= '0;
      writeEnable   <= 1'b0;
      writePtr      <= '0;
      writeValue    <= '0;
      allWriteBack  <= 1'b0;
    end else begin
      run       <= 1'b1;
      respValid <= 1'b0;
      flushDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty)        state <= head.write ? S_WR_ISSUE : S_RD_ISSUE;
          else if (flush_pending) state <= S_FL_ISSUE;
        end
        S_RD_ISSUE: begin
          readPtr <= head.addr;
          state   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rd_done) begin
            respValid <= 1'b1;
            respData  <= readValue;
            respTag   <= head_tag;
            state     <= S_IDLE;
          end else if (abort) begin
            state <= S_IDLE;
          end
        end
        S_WR_ISSUE: begin
          writePtr    <= head.addr;
          writeValue  <= head.data;
          writeEnable <= 1'b1;
          state       <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (wr_done || abort) begin
            writeEnable <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_FL_ISSUE: begin
          allWriteBack <= 1'b1;
          state        <= S_FL_WAIT;
        end
        S_FL_WAIT: begin
          if (fl_done || abort) begin
            allWriteBack <= 1'b0;
            flushDone    <= fl_done;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A new flush request wins over completion of the current one.
      if (flushReq)
        flush_pending <= 1'b1;
      else if (fl_done || (abort && (state == S_FL_WAIT)))
        flush_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a behavioural cache and program-order memory model
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             reqValid, reqReady, reqWrite;
  logic [31:0]      reqAddr, reqData;
  logic [TAG_W-1:0] reqTag;
  logic             respValid;
  logic [31:0]      respData;
  logic [TAG_W-1:0] respTag;
  logic             flushReq, flushDone;
  logic [31:0]      readPtr, readValue;
  logic             readSuccess;
  logic             writeEnable;
  logic [31:0]      writePtr, writeValue;
  logic             writeSuccess;
  logic             allWriteBack, allWriteBackSuccess;
  logic             timeoutError;

  always #5 clk = ~clk;

  mem_access_unit #(
    .QUEUE_DEPTH    (4),
    .TAG_WIDTH      (TAG_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .reqValid            (reqValid),
    .reqReady            (reqReady),
    .reqWrite            (reqWrite),
    .reqAddr             (reqAddr),
    .reqData             (reqData),
    .reqTag              (reqTag),
    .respValid           (respValid),
    .respData            (respData),
    .respTag             (respTag),
    .flushReq            (flushReq),
    .flushDone           (flushDone),
    .readPtr             (readPtr),
    .readValue           (readValue),
    .readSuccess         (readSuccess),
    .writeEnable         (writeEnable),
    .writePtr            (writePtr),
    .writeValue          (writeValue),
    .writeSuccess        (writeSuccess),
    .allWriteBack        (allWriteBack),
    .allWriteBackSuccess (allWriteBackSuccess),
    .timeoutError        (timeoutError)
  );

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } resp_t;

  typedef struct {
    logic             write;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               rd_lat;
    int               wr_lat;
    logic [31:0]      exp_data;
    int               exp_lat;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] cmem [256];
  logic [31:0] ref_mem [256];
  resp_t       exp_q [$];
  int          rd_lat = 1, wr_lat = 1, fl_lat = 1;
  bit          rd_stuck = 1'b0;
  int          cyc = 0, resp_cnt = 0, flush_done_cnt = 0, accept_cyc = 0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {reqReady, respValid, respData, respTag, flushDone, readPtr, writeEnable,
            writePtr, writeValue, allWriteBack, timeoutError};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cache: read success every rd_lat+1 cycles, write/flush succeed after lat cycles of enable.
  initial begin
    int rcnt = 0, wcnt = 0, fcnt = 0;
    readSuccess = 1'b0; readValue = '0; writeSuccess = 1'b0; allWriteBackSuccess = 1'b0;
    forever begin
      @(negedge clk);
      if (readSuccess) rcnt = 0; else rcnt++;
      readSuccess = !rd_stuck && (rcnt >= rd_lat);
      readValue   = cmem[readPtr[7:0]];
      if (writeEnable) begin
        writeSuccess = (wcnt >= wr_lat);
        if (writeSuccess) cmem[writePtr[7:0]] = writeValue;
        wcnt++;
      end else begin
        wcnt = 0;
        writeSuccess = 1'b0;
      end
      if (allWriteBack) begin
        allWriteBackSuccess = (fcnt >= fl_lat);
        fcnt++;
      end else begin
        fcnt = 0;
        allWriteBackSuccess = 1'b0;
      end
    end
  end

  // Scoreboard: every load response must match the program-order memory at issue time.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (respValid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: data=%h tag=%h with none outstanding", respData, respTag);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", respData, e.data);
          check("resp_tag", respTag, e.tag);
        end
      end
      if (flushDone) flush_done_cnt++;
    end
  end

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [TAG_W-1:0] t);
    int g = 0;
    while (!reqReady && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("push_ready", reqReady, 1);
    if (reqReady) begin
      reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d; reqTag = t;
      @(posedge clk);
      if (w) ref_mem[a[7:0]] = d;
      else   exp_q.push_back('{data: ref_mem[a[7:0]], tag: t});
      @(negedge clk);
      reqValid = 1'b0;
      accept_cyc = cyc;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 600) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vec_t             vecs [6];
    int               n, hi, base, fbase, t0;
    bit               ptr_ok;
    logic             w;
    logic [31:0]      a, d;
    logic [TAG_W-1:0] t;

    for (int i = 0; i < 256; i++) begin
      cmem[i]    = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    cmem[0] = 32'hDEADBEEF;
    ref_mem[0] = 32'hDEADBEEF;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0; reqTag = '0; flushReq = 1'b0;

    vecs[0] = '{1'b0, 32'd0, 32'd0,         4'd3,  5, 0, 32'hDEADBEEF, 0};
    vecs[1] = '{1'b1, 32'd1, 32'd50,        4'd0,  1, 3, 32'd0,        0};
    vecs[2] = '{1'b0, 32'd1, 32'd0,         4'd5,  0, 0, 32'd50,       3};
    vecs[3] = '{1'b1, 32'd2, 32'h1234_5678, 4'd0,  1, 0, 32'd0,        0};
    vecs[4] = '{1'b0, 32'd2, 32'd0,         4'd15, 2, 0, 32'h1234_5678, 0};
    vecs[5] = '{1'b0, 32'd7, 32'd0,         4'd0,  0, 0, 32'hA500_0007, 3};

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), '0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", reqReady, 1);

    for (int i = 0; i < 6; i++) begin
      rd_lat = vecs[i].rd_lat;
      wr_lat = vecs[i].wr_lat;
      repeat (2) @(negedge clk);
      push(vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].tag);
      n = 0;
      if (!vecs[i].write) begin
        ptr_ok = 1'b1;
        while (!respValid && n < 100) begin
          if ((cyc - accept_cyc) >= 2 && readPtr !== vecs[i].addr) ptr_ok = 1'b0;
          @(negedge clk);
          n++;
        end
        check("load_seen", respValid, 1);
        check("load_data", respData, vecs[i].exp_data);
        check("load_tag", respTag, vecs[i].tag);
        check("load_ptr_hold", {ptr_ok, readPtr}, {1'b1, vecs[i].addr});
        if (vecs[i].exp_lat != 0) check("load_latency", cyc - accept_cyc, vecs[i].exp_lat);
      end else begin
        while (!writeEnable && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("store_we", writeEnable, 1);
        check("store_ptr_val", {writePtr, writeValue}, {vecs[i].addr, vecs[i].data});
        hi = 0;
        while (writeEnable && hi < 100) begin
          @(negedge clk);
          hi++;
        end
        check("store_we_cycles", hi, vecs[i].wr_lat + 1);
      end
    end
    drain();

    rd_lat = 1;
    rd_stuck = 1'b1;
    repeat (2) @(negedge clk);
    push(1'b0, 32'd9, 32'd0, 4'd1);
    push(1'b0, 32'd11, 32'd0, 4'd2);
    push(1'b0, 32'd67, 32'd0, 4'd3);
    push(1'b0, 32'd1, 32'd0, 4'd4);
    check("full_ready_low", reqReady, 0);
    base = resp_cnt;
    rd_stuck = 1'b0;
    n = 0;
    while (!respValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_pop", reqReady, 1);
    drain();
    check("full_resp_count", resp_cnt - base, 4);

    rd_lat = 3;
    fl_lat = 3;
    repeat (2) @(negedge clk);
    base = resp_cnt;
    fbase = flush_done_cnt;
    push(1'b0, 32'd20, 32'd0, 4'd6);
    flushReq = 1'b1;
    push(1'b0, 32'd21, 32'd0, 4'd7);
    flushReq = 1'b0;
    check("flush_blocks_ready", reqReady, 0);
    n = 0;
    while (!allWriteBack && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("flush_after_loads", {allWriteBack, 32'(resp_cnt - base)}, {1'b1, 32'd2});
    n = 0;
    while (!flushDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("flush_done_seen", flushDone, 1);
    repeat (5) @(negedge clk);
    check("flush_done_once", flush_done_cnt - fbase, 1);
    check("ready_after_flush", {reqReady, allWriteBack}, 2'b10);

    for (int k = 0; k < 80; k++) begin
      rd_lat = int'($urandom_range(0, 4));
      wr_lat = int'($urandom_range(0, 3));
      w = ($urandom_range(0, 2) == 0);
      a = 32'($urandom_range(0, 15));
      d = $urandom;
      t = TAG_W'($urandom_range(0, 15));
      push(w, a, d, t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    rd_stuck = 1'b1;
    repeat (2) @(negedge clk);
    push(1'b0, 32'd5, 32'd0, 4'd9);
    push(1'b0, 32'd6, 32'd0, 4'd10);
    push(1'b0, 32'd7, 32'd0, 4'd11);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("reset_async_outs", all_outs(), '0);
    exp_q.delete();
    @(negedge clk);
    rd_stuck = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    base = resp_cnt;
    repeat (15) @(negedge clk);
    check("no_resp_after_reset", resp_cnt - base, 0);
    check("ready_after_release", reqReady, 1);
    push(1'b0, 32'd5, 32'd0, 4'd12);
    drain();

`ifdef MEM_ACCESS_TIMEOUT_EN
    rd_stuck = 1'b1;
    wr_lat = 1;
    repeat (2) @(negedge clk);
    check("timeout_clear", timeoutError, 0);
    push(1'b0, 32'd3, 32'd0, 4'd1);
    void'(exp_q.pop_back());
    t0 = accept_cyc;
    push(1'b1, 32'd4, 32'h77, 4'd2);
    n = 0;
    while (!timeoutError && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", cyc - t0, 10);
    rd_stuck = 1'b0;
    n = 0;
    while (!writeEnable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("store_after_timeout", {writeEnable, writePtr, writeValue}, {1'b1, 32'd4, 32'h77});
    push(1'b0, 32'd4, 32'd0, 4'd3);
    drain();
    check("timeout_sticky", timeoutError, 1);
`else
    check("timeout_tied_low", timeoutError, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

In-order load/store initiator that sits between the pipeline's memory stage and `DataCache`, acting as the requester on the cache's poll-until-success protocol. It buffers load/store requests in a small queue, drives one cache read port and the cache write port, and holds each address until the cache signals success. It returns tagged load data to the pipeline and sequences whole-cache write-back (flush) requests.

## Interface
Parameters:
- `QUEUE_DEPTH`, 4: request queue entries (power of two, ≥2).
- `TAG_WIDTH`, 4: pipeline tag width.
- `TIMEOUT_CYCLES`, 256: wait-state watchdog limit; used only with the macro.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reqValid` in 1, `reqReady` out 1: pipeline request handshake; transfer when both are high at an edge.
- `reqWrite`  in  1  1 = store, 0 = load.
- `reqAddr` in 32, `reqData` in 32, `reqTag` in `TAG_WIDTH`: request payload.
- `respValid` out 1, `respData` out 32, `respTag` out `TAG_WIDTH`: load response, one-cycle pulse, no backpressure.
- `flushReq` in 1, `flushDone` out 1: flush request level and one-cycle completion pulse.
- `readPtr` out 32, `readValue` in 32, `readSuccess` in 1: cache read port.
- `writeEnable` out 1, `writePtr` out 32, `writeValue` out 32, `writeSuccess` in 1: cache write port.
- `allWriteBack` out 1, `allWriteBackSuccess` in 1: cache flush port.
- `timeoutError`  out  1  sticky watchdog flag.

## Operation
- Queue: FIFO of {write, addr, data, tag}. `reqReady = !full && !flushPending`. The bench must not drive `reqValid` while `reqReady` is low.
- Strict program order. One cache operation is outstanding at a time.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FL_ISSUE, FL_WAIT.
- IDLE, queue not empty: go to RD_ISSUE or WR_ISSUE according to the head entry.
- IDLE, queue empty and `flushPending`: go to FL_ISSUE.
- IDLE: a non-empty queue takes priority over a pending flush, so the queue drains before the flush starts.
- *_ISSUE: register the address/data onto the cache ports. Success inputs are ignored in this cycle because they may reflect the previous address. Go to the matching *_WAIT.
- RD_WAIT, `readSuccess`=1 at the edge:
  - capture `readValue` to `respData` and the head tag to `respTag`;
  - `respValid`=1 for the following cycle;
  - pop the head; go to IDLE.
- WR_WAIT: `writeEnable` is held at 1. On `writeSuccess`=1: pop, deassert `writeEnable`, go to IDLE. Stores produce no response.
- FL_WAIT: `allWriteBack` is held at 1. On `allWriteBackSuccess`=1: clear `flushPending`, pulse `flushDone`, go to IDLE.
- `flushPending` is set on any edge where `flushReq`=1.
- A request accepted on the same edge that sets `flushPending` is ordered ahead of the flush.
- `readPtr`/`writePtr`/`writeValue` hold their last value when idle. Only the enables carry meaning.

## Timing
- Reset values: all outputs 0, queue empty, `flushPending`=0, `timeoutError`=0, state IDLE.
- Reset applied mid-operation discards in-flight and queued requests; no response is produced for them.
- Load latency: accepted at edge E → IDLE→RD_ISSUE at E+1 → RD_WAIT at E+2. If success is high at E+3, `respValid` is high during E+3..E+4. Minimum latency is 3 cycles.
- Store minimum occupancy: 3 cycles. Flush minimum occupancy: 3 cycles after the queue empties.
- Full queue: `reqReady` drops in the cycle after the edge that fills the queue. It rises in the cycle after a pop.
- Simultaneous push and pop are permitted when the queue is not full.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - a counter runs in every *_WAIT state;
  - on reaching `TIMEOUT_CYCLES` the unit sets `timeoutError` (sticky until reset), abandons the operation, pops it (loads give no response; a flush clears `flushPending` without `flushDone`), and deasserts all enables;
  - then returns to IDLE.
- Undefined: no counter; waits are unbounded; `timeoutError` is tied to 0.

## Structure
- `mem_access_pkg`: FSM state enum, queue-entry struct, address/data width constants (32).
- Sub-module `mem_access_fifo`: parameterised synchronous FIFO with full/empty flags and asynchronous active-low reset.
- Top-level module: FSM, port registers, watchdog.

## Test plan
- Load addr 0, tag 3, with the cache model returning 0xDEADBEEF after 5 cycles → one `respValid` pulse, `respData`=DEADBEEF, `respTag`=3, `readPtr`=0 throughout the wait.
- Store addr 1 ← 50, then load addr 1, tag 5 → `writeEnable` held until `writeSuccess`; the load issues afterwards and returns 50 with `respTag`=5.
- Push 4 loads (addrs 9, 11, 67, 1) while the cache stalls → `reqReady`=0 after the 4th; responses arrive in order 9, 11, 67, 1.
- `flushReq` pulsed with 2 loads queued → both responses arrive first, then `allWriteBack`=1, then `flushDone` pulses once after `allWriteBackSuccess`.
- Reset asserted during RD_WAIT → all outputs 0 immediately (asynchronous), no `respValid`, queue empty after release.
- Macro on, `TIMEOUT_CYCLES`=8, `readSuccess` stuck at 0 → `timeoutError`=1 after 8 wait cycles, no response, the next queued store proceeds normally.
